// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter sharing the register file between client A (CPU) and client B (debug).
// Optional owner lock (back-to-back ownership) is enabled by defining RF_ARB_LOCK_EN.
module rf_access_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int REGBITS    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_a_req,
    input  logic                  i_a_we,
    input  logic [REGBITS-1:0]    i_a_addr1,
    input  logic [REGBITS-1:0]    i_a_addr2,
    input  logic [DATA_WIDTH-1:0] i_a_wdata,
    input  logic                  i_a_lock,
    input  logic                  i_b_req,
    input  logic                  i_b_we,
    input  logic [REGBITS-1:0]    i_b_addr1,
    input  logic [REGBITS-1:0]    i_b_addr2,
    input  logic [DATA_WIDTH-1:0] i_b_wdata,
    input  logic                  i_b_lock,
    output logic                  o_a_gnt,
    output logic                  o_b_gnt,
    output logic                  o_a_rvalid,
    output logic                  o_b_rvalid,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic [DATA_WIDTH-1:0] o_rdata2,
    output logic                  o_rf_wr_en,
    output logic [DATA_WIDTH-1:0] o_rf_wr_data,
    output logic [REGBITS-1:0]    o_rf_addr1,
    output logic [REGBITS-1:0]    o_rf_addr2,
    input  logic [DATA_WIDTH-1:0] i_rf_rd_data1,
    input  logic [DATA_WIDTH-1:0] i_rf_rd_data2
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_rr_ptr;   // last winner: 0 = A, 1 = B
    logic                  r_owner;
    logic                  r_a_gnt;
    logic                  r_b_gnt;
    logic                  r_a_rvalid;
    logic                  r_b_rvalid;
    logic                  r_rf_wr_en;
    logic [DATA_WIDTH-1:0] r_rf_wr_data;
    logic [REGBITS-1:0]    r_rf_addr1;
    logic [REGBITS-1:0]    r_rf_addr2;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic [DATA_WIDTH-1:0] r_rdata2;

    logic                  w_any_req;
    logic                  w_win_b;
    logic                  w_hold_ptr;
    logic                  w_win_we;
    logic [REGBITS-1:0]    w_win_addr1;
    logic [REGBITS-1:0]    w_win_addr2;
    logic [DATA_WIDTH-1:0] w_win_wdata;

`ifdef RF_ARB_LOCK_EN
    logic w_owner_lock;
    logic w_owner_req;
    assign w_owner_lock = r_owner ? i_b_lock : i_a_lock;
    assign w_owner_req  = r_owner ? i_b_req  : i_a_req;
`else
    logic w_unused_lock;
    assign w_unused_lock = i_a_lock ^ i_b_lock;
`endif

    // Winner selection and winner field mux
    always_comb begin
        w_any_req  = i_a_req | i_b_req;
        w_win_b    = 1'b0;
        w_hold_ptr = 1'b0;
        if (i_a_req && i_b_req) begin
            w_win_b = ~r_rr_ptr;
        end else begin
            w_win_b = i_b_req;
        end
`ifdef RF_ARB_LOCK_EN
        // A locked owner keeps the RF across back-to-back transactions only
        if ((r_state == ST_RESP) && w_owner_lock && w_owner_req) begin
            w_win_b    = r_owner;
            w_hold_ptr = 1'b1;
        end else begin
            w_hold_ptr = 1'b0;
        end
`endif
        if (w_win_b) begin
            w_win_we    = i_b_we;
            w_win_addr1 = i_b_addr1;
            w_win_addr2 = i_b_addr2;
            w_win_wdata = i_b_wdata;
        end else begin
            w_win_we    = i_a_we;
            w_win_addr1 = i_a_addr1;
            w_win_addr2 = i_a_addr2;
            w_win_wdata = i_a_wdata;
        end
    end

    // Transaction FSM with registered RF controls and client handshakes
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= 1'b1;
            r_owner      <= 1'b0;
            r_a_gnt      <= 1'b0;
            r_b_gnt      <= 1'b0;
            r_a_rvalid   <= 1'b0;
            r_b_rvalid   <= 1'b0;
            r_rf_wr_en   <= 1'b0;
            r_rf_wr_data <= {DATA_WIDTH{1'b0}};
            r_rf_addr1   <= {REGBITS{1'b0}};
            r_rf_addr2   <= {REGBITS{1'b0}};
            r_rdata1     <= {DATA_WIDTH{1'b0}};
            r_rdata2     <= {DATA_WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    r_a_rvalid <= 1'b0;
                    r_b_rvalid <= 1'b0;
                    if (w_any_req) begin
                        r_state      <= ST_ISSUE;
                        r_owner      <= w_win_b;
                        r_rr_ptr     <= w_hold_ptr ? r_rr_ptr : w_win_b;
                        r_a_gnt      <= ~w_win_b;
                        r_b_gnt      <= w_win_b;
                        r_rf_wr_en   <= w_win_we;
                        r_rf_wr_data <= w_win_wdata;
                        r_rf_addr1   <= w_win_addr1;
                        r_rf_addr2   <= w_win_addr2;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_a_gnt    <= 1'b0;
                        r_b_gnt    <= 1'b0;
                        r_rf_wr_en <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    // RF write commits on this same edge, so capture is the pre-write value
                    r_state    <= ST_RESP;
                    r_a_gnt    <= 1'b0;
                    r_b_gnt    <= 1'b0;
                    r_rf_wr_en <= 1'b0;
                    r_a_rvalid <= ~r_owner;
                    r_b_rvalid <= r_owner;
                    r_rdata1   <= i_rf_rd_data1;
                    r_rdata2   <= i_rf_rd_data2;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_a_gnt    <= 1'b0;
                    r_b_gnt    <= 1'b0;
                    r_a_rvalid <= 1'b0;
                    r_b_rvalid <= 1'b0;
                    r_rf_wr_en <= 1'b0;
                end
            endcase
        end
    end

    assign o_a_gnt      = r_a_gnt;
    assign o_b_gnt      = r_b_gnt;
    assign o_a_rvalid   = r_a_rvalid;
    assign o_b_rvalid   = r_b_rvalid;
    assign o_rdata1     = r_rdata1;
    assign o_rdata2     = r_rdata2;
    assign o_rf_wr_en   = r_rf_wr_en;
    assign o_rf_wr_data = r_rf_wr_data;
    assign o_rf_addr1   = r_rf_addr1;
    assign o_rf_addr2   = r_rf_addr2;

endmodule
